// File: rtl/pe_sched.sv
// pe_sched: stage/group scheduler for one PE0-style butterfly lane.
//
// Runs one full transform per accepted start (Kyber/Dilithium, NTT/INTT). For every stage
// it spends one CFG cycle loading the lane configuration, issues 2^GRP_W operand groups,
// then drains the lane before touching the configuration again. A {valid, addr} delay line
// follows the issued operands so write-back address/valid line up with the lane output.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, op            transform request and mode (00 K-NTT, 01 K-INTT, 10 D-NTT, 11 D-INTT)
//   busy, done           busy from accepted start until done; done is a one-cycle pulse
//   sel_0, sel_1, KD_mode  lane configuration (registered)
//   rd_en, rd_addr       operand issue strobe and group index
//   tw_addr              twiddle ROM index
//   wb_valid, wb_addr    lane output valid and its write-back group index
//   stage                current stage index
module pe_sched #(
    parameter int unsigned GRP_W    = 7,
    parameter int unsigned K_STAGES = 7,
    parameter int unsigned D_STAGES = 7,
    parameter int unsigned LAT_FWD  = 4,
    parameter int unsigned LAT_INV  = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic             sel_0,
    output logic             sel_1,
    output logic             KD_mode,
    output logic             rd_en,
    output logic [GRP_W-1:0] rd_addr,
    output logic [GRP_W:0]   tw_addr,
    output logic             wb_valid,
    output logic [GRP_W-1:0] wb_addr,
    output logic [2:0]       stage
);

    localparam int unsigned TW_W      = GRP_W + 1;
    localparam int unsigned CNT_W     = $clog2(LAT_INV + 1);
    // Forward-latency operands enter the delay line part-way along so that the single
    // output tap at the end always sees the right latency and nothing lingers past it.
    localparam int unsigned FWD_ENTRY = LAT_INV - LAT_FWD;

    typedef enum logic [2:0] {StIdle, StCfg, StRun, StDrain, StFin} state_e;

    state_e                        state_q, state_d;
    logic [1:0]                    op_q, op_d;
    logic [2:0]                    stage_q, stage_d;
    logic [2:0]                    cfg_q, cfg_d;      // {sel_1, sel_0, KD_mode}
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          rd_en_q, rd_en_d;
    logic [GRP_W-1:0]              grp_q, grp_d;
    logic [TW_W-1:0]               tw_q, tw_d;
    logic [CNT_W-1:0]              drain_q, drain_d;
    logic [LAT_INV-1:0]            pipe_v_q, pipe_v_d;
    logic [LAT_INV-1:0][GRP_W-1:0] pipe_a_q, pipe_a_d;

    logic [CNT_W-1:0]              lat;
    int unsigned                   entry;

    function automatic logic [2:0] last_of(input logic [1:0] o);
        return o[1] ? 3'(D_STAGES - 1) : 3'(K_STAGES - 1);
    endfunction

    function automatic logic [2:0] cfg_for(input logic [1:0] o, input logic [2:0] s);
        logic [2:0] c;
        case (o)
            2'b00:   c = (s == 3'd0) ? 3'b000 : 3'b010;
            2'b01:   c = (s == last_of(o)) ? 3'b100 : 3'b110;
            2'b10:   c = 3'b011;
            default: c = 3'b101;
        endcase
        return c;
    endfunction

    function automatic logic [TW_W-1:0] tw_for(input logic [1:0] o, input logic [2:0] s,
                                               input logic [GRP_W-1:0] g);
        logic [TW_W-1:0] ge;
        ge = {1'b0, g};
        if (!o[0]) begin
            return (TW_W'(1) << s) | (ge >> (GRP_W - 32'(s)));
        end
        return TW_W'(1 << GRP_W) - (TW_W'(1) << s) + (ge >> s);
    endfunction

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        stage_d = stage_q;
        cfg_d   = cfg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_en_d = rd_en_q;
        grp_d   = grp_q;
        tw_d    = tw_q;
        drain_d = drain_q;
        lat     = cfg_q[2] ? CNT_W'(LAT_INV) : CNT_W'(LAT_FWD);

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    busy_d  = 1'b1;
                    stage_d = 3'd0;
                    cfg_d   = cfg_for(op, 3'd0);
                    state_d = StCfg;
                end
            end
            StCfg: begin
                rd_en_d = 1'b1;
                grp_d   = '0;
                tw_d    = tw_for(op_q, stage_q, '0);
                state_d = StRun;
            end
            StRun: begin
                if (grp_q == {GRP_W{1'b1}}) begin
                    rd_en_d = 1'b0;
                    grp_d   = '0;
                    tw_d    = '0;
                    drain_d = lat - 1'b1;
                    state_d = StDrain;
                end else begin
                    grp_d = grp_q + 1'b1;
                    tw_d  = tw_for(op_q, stage_q, grp_q + 1'b1);
                end
            end
            StDrain: begin
                // Last DRAIN cycle is the one emitting the stage's final write-back.
                if (drain_q == '0) begin
                    if (stage_q == last_of(op_q)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cfg_d   = 3'b000;
                        stage_d = 3'd0;
                        state_d = StFin;
                    end else begin
                        stage_d = stage_q + 3'd1;
                        cfg_d   = cfg_for(op_q, stage_q + 3'd1);
                        state_d = StCfg;
                    end
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        pipe_v_d = {pipe_v_q[LAT_INV-2:0], 1'b0};
        pipe_a_d = {pipe_a_q[LAT_INV-2:0], GRP_W'(0)};
        entry    = cfg_q[2] ? 0 : FWD_ENTRY;
        for (int unsigned i = 0; i < LAT_INV; i++) begin
            if (i == entry) begin
                pipe_v_d[i] = rd_en_q;
                pipe_a_d[i] = grp_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            op_q     <= 2'b00;
            stage_q  <= 3'd0;
            cfg_q    <= 3'b000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            grp_q    <= '0;
            tw_q     <= '0;
            drain_q  <= '0;
            pipe_v_q <= '0;
            pipe_a_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            stage_q  <= stage_d;
            cfg_q    <= cfg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rd_en_q  <= rd_en_d;
            grp_q    <= grp_d;
            tw_q     <= tw_d;
            drain_q  <= drain_d;
            pipe_v_q <= pipe_v_d;
            pipe_a_q <= pipe_a_d;
        end
    end

    // A new configuration may only become visible once the delay line is empty.
    cfg_stable_a: assert property (@(posedge clk) disable iff (rst)
        (cfg_d != cfg_q) |-> (pipe_v_d == '0));

    assign busy     = busy_q;
    assign done     = done_q;
    assign sel_1    = cfg_q[2];
    assign sel_0    = cfg_q[1];
    assign KD_mode  = cfg_q[0];
    assign rd_en    = rd_en_q;
    assign rd_addr  = grp_q;
    assign tw_addr  = tw_q;
    assign wb_valid = pipe_v_q[LAT_INV-1];
    assign wb_addr  = pipe_a_q[LAT_INV-1];
    assign stage    = stage_q;

endmodule

// File: tb/tb_pe_sched.sv
module tb_pe_sched;

    localparam int GRP_W    = 3;
    localparam int K_STAGES = 3;
    localparam int D_STAGES = 3;
    localparam int LAT_FWD  = 4;
    localparam int LAT_INV  = 11;
    localparam int NG       = 1 << GRP_W;
    localparam int MAXC     = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [1:0]       op;
    logic             busy, done, sel_0, sel_1, KD_mode, rd_en, wb_valid;
    logic [GRP_W-1:0] rd_addr, wb_addr;
    logic [GRP_W:0]   tw_addr;
    logic [2:0]       stage;

    always #5 clk = ~clk;

    pe_sched #(
        .GRP_W   (GRP_W),
        .K_STAGES(K_STAGES),
        .D_STAGES(D_STAGES),
        .LAT_FWD (LAT_FWD),
        .LAT_INV (LAT_INV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .busy    (busy),
        .done    (done),
        .sel_0   (sel_0),
        .sel_1   (sel_1),
        .KD_mode (KD_mode),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .tw_addr (tw_addr),
        .wb_valid(wb_valid),
        .wb_addr (wb_addr),
        .stage   (stage)
    );

    int checks = 0;
    int errors = 0;

    // Expected trace, indexed by cycle offset from the cycle in which start was sampled.
    int e_busy[MAXC], e_done[MAXC], e_cfg[MAXC], e_rd[MAXC], e_rda[MAXC];
    int e_tw[MAXC], e_wb[MAXC], e_wba[MAXC], e_stage[MAXC];
    int e_total;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, k, act, exp);
        end
    endtask

    function automatic int mode_cfg(input logic [1:0] o, input int s, input int ns);
        case (o)
            2'b00:   return (s == 0) ? 0 : 2;     // K_2_NTT then K_4_NTT
            2'b01:   return (s == ns - 1) ? 4 : 6; // K_4_INTT then K_2_INTT
            2'b10:   return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int twid(input bit inv, input int s, input int g);
        if (!inv) return (2 ** s) + g / (2 ** (GRP_W - s));
        return (2 ** GRP_W - 2 ** s + g / (2 ** s)) % (2 ** (GRP_W + 1));
    endfunction

    task automatic build_model(input logic [1:0] o);
        int k, ns, lat;
        bit inv;
        inv = o[0];
        ns  = o[1] ? D_STAGES : K_STAGES;
        lat = inv ? LAT_INV : LAT_FWD;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_cfg[i] = 0; e_rd[i] = 0; e_rda[i] = 0;
            e_tw[i] = 0; e_wb[i] = 0; e_wba[i] = 0; e_stage[i] = 0;
        end
        k = 1;
        for (int s = 0; s < ns; s++) begin
            for (int j = 0; j < 1 + NG + lat; j++) begin
                e_busy[k]  = 1;
                e_cfg[k]   = mode_cfg(o, s, ns);
                e_stage[k] = s;
                if (j >= 1 && j <= NG) begin
                    e_rd[k]        = 1;
                    e_rda[k]       = j - 1;
                    e_tw[k]        = twid(inv, s, j - 1);
                    e_wb[k + lat]  = 1;
                    e_wba[k + lat] = j - 1;
                end
                k++;
            end
        end
        e_done[k] = 1;
        e_total   = k;
    endtask

    task automatic run_transform(input logic [1:0] o, input bit noise, input bit fin_start,
                                 output int done_at, output int cfg_first,
                                 output int cfg_last, output int lat_obs);
        int first_rd, first_wb, cfg;
        build_model(o);
        done_at = -1; first_rd = -1; first_wb = -1; cfg_first = -1; cfg_last = -1;
        @(posedge clk); #1;
        check("idle_busy", 0, 32'(busy), 0);
        check("idle_done", 0, 32'(done), 0);
        start = 1'b1;
        op    = o;
        for (int k = 1; k <= e_total; k++) begin
            @(posedge clk); #1;
            cfg = int'({sel_1, sel_0, KD_mode});
            check("busy", k, 32'(busy), e_busy[k]);
            check("done", k, 32'(done), e_done[k]);
            check("cfg", k, cfg, e_cfg[k]);
            check("rd_en", k, 32'(rd_en), e_rd[k]);
            check("wb_valid", k, 32'(wb_valid), e_wb[k]);
            if (e_rd[k] != 0) begin
                check("rd_addr", k, 32'(rd_addr), e_rda[k]);
                check("tw_addr", k, 32'(tw_addr), e_tw[k]);
            end
            if (e_wb[k] != 0) check("wb_addr", k, 32'(wb_addr), e_wba[k]);
            if (e_busy[k] != 0) check("stage", k, 32'(stage), e_stage[k]);
            if (done && done_at < 0) done_at = k;
            if (rd_en && first_rd < 0) first_rd = k;
            if (wb_valid && first_wb < 0) first_wb = k;
            if (k == 1) cfg_first = cfg;
            if (k == e_total - 1) cfg_last = cfg;
            if (k == e_total) begin
                start = fin_start;
                op    = 2'($urandom);
            end else if (noise) begin
                start = 1'($urandom);
                op    = 2'($urandom);
            end else begin
                start = 1'b0;
                op    = o;
            end
        end
        lat_obs = first_wb - first_rd;
    endtask

    typedef struct {
        logic [1:0] op;
        int         cfg_first;
        int         cfg_last;
        int         lat;
        int         done_at;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int d, cf, cl, lo;
        logic [1:0] ro;

        tbl[0] = '{op: 2'b00, cfg_first: 0, cfg_last: 2, lat: 4,  done_at: 40};
        tbl[1] = '{op: 2'b01, cfg_first: 6, cfg_last: 4, lat: 11, done_at: 61};
        tbl[2] = '{op: 2'b10, cfg_first: 3, cfg_last: 3, lat: 4,  done_at: 40};
        tbl[3] = '{op: 2'b11, cfg_first: 5, cfg_last: 5, lat: 11, done_at: 61};

        rst = 1'b1; start = 1'b0; op = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 0, 32'(busy), 0);
        check("rst_done", 0, 32'(done), 0);
        check("rst_cfg", 0, 32'({sel_1, sel_0, KD_mode}), 0);
        check("rst_rd_en", 0, 32'(rd_en), 0);
        check("rst_rd_addr", 0, 32'(rd_addr), 0);
        check("rst_tw_addr", 0, 32'(tw_addr), 0);
        check("rst_wb_valid", 0, 32'(wb_valid), 0);
        check("rst_wb_addr", 0, 32'(wb_addr), 0);
        check("rst_stage", 0, 32'(stage), 0);
        rst = 1'b0;

        // Table of one transform per mode, issued back-to-back.
        for (int i = 0; i < 4; i++) begin
            run_transform(tbl[i].op, 1'b0, 1'b0, d, cf, cl, lo);
            check("tbl_done_at", i, d, tbl[i].done_at);
            check("tbl_cfg_first", i, cf, tbl[i].cfg_first);
            check("tbl_cfg_last", i, cl, tbl[i].cfg_last);
            check("tbl_latency", i, lo, tbl[i].lat);
        end

        // start/op noise during RUN and start held in FIN, then back-to-back timing repeat.
        run_transform(2'b00, 1'b1, 1'b1, d, cf, cl, lo);
        check("noise_done_at", 0, d, 40);
        run_transform(2'b00, 1'b0, 1'b0, d, cf, cl, lo);
        check("b2b_done_at", 0, d, 40);

        // Reset in the middle of stage 1 of a K-NTT.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("pre_rst_busy", 18, 32'(busy), 1);
        check("pre_rst_rd_en", 18, 32'(rd_en), 1);
        check("pre_rst_stage", 18, 32'(stage), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 0, 32'(busy), 0);
        check("mid_rst_done", 0, 32'(done), 0);
        check("mid_rst_cfg", 0, 32'({sel_1, sel_0, KD_mode}), 0);
        check("mid_rst_rd_en", 0, 32'(rd_en), 0);
        check("mid_rst_wb_valid", 0, 32'(wb_valid), 0);
        check("mid_rst_stage", 0, 32'(stage), 0);
        check("mid_rst_tw_addr", 0, 32'(tw_addr), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk); #1;
            check("post_rst_wb_valid", k, 32'(wb_valid), 0);
            check("post_rst_done", k, 32'(done), 0);
        end
        run_transform(2'b00, 1'b0, 1'b0, d, cf, cl, lo);
        check("post_rst_done_at", 0, d, 40);

        // Randomized transforms against the reference trace.
        for (int r = 0; r < 8; r++) begin
            ro = 2'($urandom);
            run_transform(ro, 1'($urandom), 1'($urandom), d, cf, cl, lo);
            check("rnd_done_at", r, d, e_total);
            check("rnd_latency", r, lo, ro[0] ? LAT_INV : LAT_FWD);
        end

        @(posedge clk); #1;
        start = 1'b0;
        check("end_busy", 0, 32'(busy), 0);
        @(posedge clk); #1;
        check("end_done", 0, 32'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_sched.md
Name: pe_sched

Overview:
- Stage/group scheduler for one PE0-style butterfly lane.
- On `start` it runs a full transform in one of four modes: Kyber NTT, Kyber INTT, Dilithium NTT, Dilithium INTT.
- Per cycle it drives the lane configuration `{sel_1, sel_0, KD_mode}`, the operand read address and the twiddle ROM address. It also tracks in-flight operands so that write-back address and valid line up with the lane output.
- Configuration changes only while the lane pipeline is empty, so the internal twiddle delay lines never mix modes.

Parameters:
- GRP_W, 7, group counter width; groups per stage = 2^GRP_W.
- K_STAGES, 7, stages per Kyber transform (1..GRP_W).
- D_STAGES, 7, stages per Dilithium transform (1..GRP_W).
- LAT_FWD, 4, lane latency (cycles) when sel_1=0.
- LAT_INV, 11, lane latency (cycles) when sel_1=1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, begin transform; sampled only in IDLE.
- op, input, 2, 00 K-NTT, 01 K-INTT, 10 D-NTT, 11 D-INTT; captured with start.
- busy, output, 1, high from accepted start until done.
- done, output, 1, one-cycle pulse after last write-back.
- sel_0, output, 1, lane config bit.
- sel_1, output, 1, lane config bit.
- KD_mode, output, 1, lane config bit.
- rd_en, output, 1, operand issue strobe.
- rd_addr, output, GRP_W, operand group index.
- tw_addr, output, GRP_W+1, twiddle ROM index.
- wb_valid, output, 1, lane output valid.
- wb_addr, output, GRP_W, write-back group index for the current lane output.
- stage, output, 3, current stage index.

Behaviour:
- Reset (async, immediate): state=IDLE; busy, done, rd_en, wb_valid, sel_0, sel_1, KD_mode = 0; all addresses and stage = 0; delay lines cleared.
- States: IDLE -> CFG -> RUN -> DRAIN -> (CFG for next stage | FIN) -> IDLE.
- IDLE:
  - start=1 captures op, sets busy next cycle, stage=0, goes to CFG.
  - start in any other state is ignored.
- Per-stage lane config (sel_1, sel_0, KD_mode), registered outputs:
  - K-NTT: stage 0 = 000 (K_2_NTT); stages ≥1 = 010 (K_4_NTT).
  - K-INTT: stages 0..K_STAGES-2 = 110 (K_4_INTT); last stage = 100 (K_2_INTT).
  - D-NTT: every stage 011.
  - D-INTT: every stage 101.
- CFG:
  - Exactly one cycle.
  - Config outputs take the stage value.
  - rd_en=0.
- RUN:
  - rd_en=1 every cycle.
  - rd_addr = grp, counting 0 .. 2^GRP_W-1.
  - Leaves for DRAIN after grp = max; grp wraps to 0.
- tw_addr (s = stage):
  - NTT modes: (1<<s) | (grp >> (GRP_W-s)). Stage 0 gives constant 1.
  - INTT modes: (2^GRP_W - (1<<s)) + (grp >> s), truncated to GRP_W+1 bits.
- Write-back delay:
  - Track with a shift register of depth L = LAT_INV carrying {valid, addr}; tap at LAT_FWD when sel_1=0, at LAT_INV when sel_1=1.
  - wb_valid/wb_addr equal rd_en/rd_addr delayed by exactly L cycles.
- DRAIN:
  - rd_en=0; config outputs held.
  - Stays until the final wb_valid of the stage has been emitted (L cycles after the last rd_en).
  - Then, if stage < last: stage+1 and go to CFG. Otherwise go to FIN.
  - This guarantees no stage overlap (RAW hazard on the in-place buffer) and no config change with data in flight.
- FIN:
  - done=1 for one cycle, busy=0 in the same cycle.
  - Config outputs return to 000.
  - Then IDLE.
- Per-stage cycle count: 1 + 2^GRP_W + L. Total = stages × that + 1 (FIN).
- start coincident with FIN: ignored. A new start is only sampled in IDLE.
- rst asserted mid-transform: all outputs go to reset values immediately. No done pulse is generated. The in-flight wb_valid pipeline is flushed.
- Config outputs never change while any delay-line valid bit is set. Assertion required.

Test Plan:
- K-NTT, GRP_W=3, K_STAGES=3, LAT_FWD=4:
  - stage 0 config=000, tw_addr=1 for all 8 groups;
  - stages 1–2 config=010; stage 1 tw_addr=2,2,2,2,3,3,3,3;
  - wb_valid exactly 4 cycles after each rd_en;
  - done at cycle 3×(1+8+4)+1 after start.
- K-INTT, GRP_W=3, K_STAGES=3, LAT_INV=11:
  - configs 110, 110, 100;
  - wb_addr 0..7 appears 11 cycles after rd_addr 0..7;
  - no rd_en during DRAIN.
- D-INTT: every stage config=101, wb latency 11. D-NTT: config=011, wb latency 4.
- start pulsed during RUN and during FIN: ignored; op change mid-run has no effect; busy stays high until done.
- rst raised mid-stage 1 of K-NTT:
  - all outputs 0 in the same cycle, no done;
  - a subsequent start runs a clean full transform.
- Back-to-back: start in the cycle after done gives a second full transform with identical timing.
